// File: rtl/shift_register.sv
// Loadable serial-in / parallel-out / serial-out shift register; each edge loads or shifts left.
// Define SHIFT_REGISTER_GENERATE_EN to build the register as a per-bit generate chain.
module shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic             i_ser_in,
    input  logic [WIDTH-1:0] i_par_in,
    output logic [WIDTH-1:0] o_par_out,
    output logic             o_ser_out
);

    logic [WIDTH-1:0] sr_q;

`ifdef SHIFT_REGISTER_GENERATE_EN
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        logic shift_src;
        logic bit_d;
        logic bit_q;

        // Bit 0 takes the serial input; every other bit takes its lower neighbour.
        if (k == 0) begin : g_lsb
            assign shift_src = i_ser_in;
        end else begin : g_upper
            assign shift_src = sr_q[k-1];
        end

        always_comb begin
            bit_d = i_load ? i_par_in[k] : shift_src;
        end

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                bit_q <= 1'b0;
            end else begin
                bit_q <= bit_d;
            end
        end

        assign sr_q[k] = bit_q;
    end
`else
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = i_load ? i_par_in : {sr_q[WIDTH-2:0], i_ser_in};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end
`endif

    assign o_par_out = sr_q;
    assign o_ser_out = sr_q[WIDTH-1];

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register: driver pushes model expectations, monitor pops and compares.
module tb_shift_register;

    localparam int WIDTH = 8;

    logic             i_clk;
    logic             i_rstn;
    logic             i_load;
    logic             i_ser_in;
    logic [WIDTH-1:0] i_par_in;
    logic [WIDTH-1:0] o_par_out;
    logic             o_ser_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state as a plain integer: load replaces it, shift is multiply-by-two plus bit, mod 2^WIDTH.
    int model = 0;
    logic [WIDTH:0] exp_q[$];

    shift_register #(.WIDTH(WIDTH)) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_load   (i_load),
        .i_ser_in (i_ser_in),
        .i_par_in (i_par_in),
        .o_par_out(o_par_out),
        .o_ser_out(o_ser_out)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got par=%h ser=%b, expected par=%h ser=%b @%0t",
                     name, act[WIDTH:1], act[0], exp[WIDTH:1], exp[0], $time);
        end
    endtask

    function automatic logic [WIDTH:0] model_out();
        logic [WIDTH-1:0] v;
        v = model[WIDTH-1:0];
        return {v, v[WIDTH-1]};
    endfunction

    // One clock cycle: called at a negative edge, returns at the next negative edge.
    task automatic cycle(input logic load, input logic ser, input logic [WIDTH-1:0] par);
        i_load   = load;
        i_ser_in = ser;
        i_par_in = par;
        @(posedge i_clk);
        if (i_rstn) begin
            if (load) model = int'(par);
            else      model = (model * 2 + int'(ser)) % (1 << WIDTH);
            exp_q.push_back(model_out());
        end
        @(negedge i_clk);
    endtask

    // Monitor: the register presents a new result after every edge out of reset.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                chk("scoreboard", {o_par_out, o_ser_out}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    logic [7:0] ser_seq;
    logic [7:0] des_seq;

    initial begin
        i_rstn   = 1'b0;
        i_load   = 1'b1;
        i_ser_in = 1'b0;
        i_par_in = 8'hFF;
        ser_seq  = 8'b1010_0101;
        des_seq  = 8'b1100_1010;

        // Reset held with a pending load: outputs stay zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("reset_hold", {o_par_out, o_ser_out}, {8'h00, 1'b0});
        end
        i_rstn = 1'b1;
        model  = 0;
        cycle(1'b1, 1'b0, 8'hFF);
        chk("reset_release", {o_par_out, o_ser_out}, {8'hFF, 1'b1});

        // Load, then serialise MSB first.
        cycle(1'b1, 1'b0, 8'hA5);
        chk("load_a5", {o_par_out, o_ser_out}, {8'hA5, 1'b1});
        for (int i = 7; i >= 0; i--) begin
            chk("serialise_bit", {o_par_out, o_ser_out}, {o_par_out, ser_seq[i]});
            cycle(1'b0, 1'b0, $urandom_range(0, 255));
        end
        chk("serialise_end", {o_par_out, o_ser_out}, {8'h00, 1'b0});

        // Deserialise from zero.
        cycle(1'b1, 1'b1, 8'h00);
        for (int i = 7; i >= 0; i--) cycle(1'b0, des_seq[i], $urandom_range(0, 255));
        chk("deserialise", {o_par_out, o_ser_out}, {8'hCA, 1'b1});

        // Load wins over the serial bit.
        cycle(1'b1, 1'b1, 8'h3C);
        chk("priority", {o_par_out, o_ser_out}, {8'h3C, 1'b0});

        // Asynchronous reset in the middle of a shift-out.
        cycle(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
        chk("pre_reset", {o_par_out, o_ser_out}, {8'hF8, 1'b1});
        #2;
        i_rstn = 1'b0;
        #1;
        chk("async_reset", {o_par_out, o_ser_out}, {8'h00, 1'b0});
        model = 0;
        @(negedge i_clk);
        chk("reset_low_edge", {o_par_out, o_ser_out}, {8'h00, 1'b0});
        i_rstn = 1'b1;
        cycle(1'b0, 1'b1, 8'h00);
        chk("after_reset_shift", {o_par_out, o_ser_out}, {8'h01, 1'b0});

        // Random vectors against the model.
        for (int i = 0; i < 24; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));
        end

        @(negedge i_clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
